// File: rtl/gpu_pkg.sv
// Shared GPU constants and write-buffer state encoding.
// The memory side uses this package too.
package gpu_pkg;

  localparam int GPU_FMA_COUNT  = 2;
  localparam int GPU_WORD_WIDTH = 16;
  localparam int GPU_LINE_WIDTH = GPU_FMA_COUNT * 3 * GPU_WORD_WIDTH;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_HOLD  = 2'd1,
    WB_STALL = 2'd2
  } wb_state_e;

endpackage

// File: rtl/fma_line_assembler.sv
// Gathers per-lane FMA results into one line, tracking a fill mask and dropped strobes.
// line_out and complete_out already include this cycle's accepted strobes.
module fma_line_assembler import gpu_pkg::*; #(
  parameter int FMA_COUNT  = GPU_FMA_COUNT,
  parameter int WORD_WIDTH = GPU_WORD_WIDTH,
  parameter int LINE_WIDTH = FMA_COUNT * 3 * WORD_WIDTH
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0] lane_data_in,
  input  logic [FMA_COUNT-1:0]            lane_valid_in,
  input  logic                            accept_in,
  input  logic                            flush_in,
  input  logic                            transfer_in,
  output logic [LINE_WIDTH-1:0]           line_out,
  output logic                            complete_out,
  output logic                            overflow_error_out
);

  logic [FMA_COUNT*WORD_WIDTH-1:0] words_q, words_m, words_d;
  logic [FMA_COUNT-1:0]            mask_q, mask_m, mask_d;
  logic                            ovf_q, ovf_d;
  logic                            drop;

  always_comb begin
    words_m = words_q;
    mask_m  = mask_q;
    drop    = 1'b0;
    for (int unsigned i = 0; i < FMA_COUNT; i++) begin
      if (lane_valid_in[i]) begin
        if (accept_in && !mask_q[i]) begin
          words_m[i*WORD_WIDTH +: WORD_WIDTH] = lane_data_in[i*WORD_WIDTH +: WORD_WIDTH];
          mask_m[i] = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end

    complete_out = (&mask_m) || (flush_in && (|mask_m));

    // Lane i result sits in word 3i+2; words 3i and 3i+1 stay zero.
    line_out = '0;
    for (int unsigned i = 0; i < FMA_COUNT; i++) begin
      line_out[LINE_WIDTH - (3*i + 3)*WORD_WIDTH +: WORD_WIDTH] =
        words_m[i*WORD_WIDTH +: WORD_WIDTH];
    end

    words_d = transfer_in ? '0 : words_m;
    mask_d  = transfer_in ? '0 : mask_m;
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      words_q <= '0;
      mask_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      words_q <= words_d;
      mask_q  <= mask_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow_error_out = ovf_q;

endmodule

// File: rtl/fma_write_buffer.sv
// Two-line write buffer between FMA result lanes and memory: one assembly line
// plus one output line, with back-pressure and sticky overflow reporting.
module fma_write_buffer import gpu_pkg::*; #(
  parameter int FMA_COUNT  = GPU_FMA_COUNT,
  parameter int WORD_WIDTH = GPU_WORD_WIDTH,
  parameter int LINE_WIDTH = FMA_COUNT * 3 * WORD_WIDTH
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0] fma_c_in,
  input  logic [FMA_COUNT-1:0]            fma_c_valid_in,
  input  logic                            flush_in,
  output logic [LINE_WIDTH-1:0]           buffer_read_out,
  output logic                            buffer_valid_out,
  input  logic                            buffer_ack_in,
  output logic                            ready_out,
  output logic                            overflow_error_out
);

  wb_state_e             state_q, state_d;
  logic [LINE_WIDTH-1:0] out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;

  logic [LINE_WIDTH-1:0] asm_line;
  logic                  asm_complete;
  logic                  transfer;

  // A finished line moves out when the output slot is free or being freed now.
  assign transfer = asm_complete && ((state_q == WB_EMPTY) || buffer_ack_in);

  fma_line_assembler #(
    .FMA_COUNT  (FMA_COUNT),
    .WORD_WIDTH (WORD_WIDTH),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_assembler (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .lane_data_in       (fma_c_in),
    .lane_valid_in      (fma_c_valid_in),
    .accept_in          (ready_q),
    .flush_in           (flush_in),
    .transfer_in        (transfer),
    .line_out           (asm_line),
    .complete_out       (asm_complete),
    .overflow_error_out (overflow_error_out)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    unique case (state_q)
      WB_EMPTY: begin
        if (transfer) begin
          state_d = WB_HOLD;
          out_d   = asm_line;
        end
      end
      WB_HOLD: begin
        if (transfer) begin
          out_d = asm_line;
        end else if (buffer_ack_in) begin
          state_d = WB_EMPTY;
          out_d   = '0;
        end else if (asm_complete) begin
          state_d = WB_STALL;
        end
      end
      WB_STALL: begin
        if (buffer_ack_in) begin
          state_d = WB_HOLD;
          out_d   = asm_line;
        end
      end
      default: begin
        state_d = WB_EMPTY;
        out_d   = '0;
      end
    endcase
    valid_d = (state_d != WB_EMPTY);
    ready_d = (state_d != WB_STALL);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= WB_EMPTY;
      out_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign buffer_read_out  = out_q;
  assign buffer_valid_out = valid_q;
  assign ready_out        = ready_q;

endmodule

// File: doc/fma_write_buffer.md
FMA_WRITE_BUFFER -- requirements
Module: fma_write_buffer

Interface
REQ-001 Parameter FMA_COUNT, default 2, number of FMA result lanes.
REQ-002 Parameter WORD_WIDTH, default 16, bits per word.
REQ-003 Parameter LINE_WIDTH, default 96, FMA_COUNT*3*WORD_WIDTH.
REQ-004 One clock; reset is asynchronous and active-high; ports are named clk_in and rst_in.
REQ-005 clk_in  input  1  system clock.
REQ-006 rst_in  input  1  asynchronous active-high reset.
REQ-007 fma_c_in  input  FMA_COUNT*WORD_WIDTH  lane i result at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-008 fma_c_valid_in  input  FMA_COUNT  per-lane result strobe, one cycle per result.
REQ-009 flush_in  input  1  force the partial line to output.
REQ-010 buffer_read_out  output  LINE_WIDTH  line presented to memory.
REQ-011 buffer_valid_out  output  1  buffer_read_out holds a complete or flushed line.
REQ-012 buffer_ack_in  input  1  one-cycle pulse: memory has consumed the line (LOADB done).
REQ-013 ready_out  output  1  all lanes may strobe next cycle.
REQ-014 overflow_error_out  output  1  sticky: a result was dropped.

Function
REQ-015 Word k of a line SHALL occupy bits [LINE_WIDTH-(k+1)*WORD_WIDTH +: WORD_WIDTH], word 0 at the MSB end; lane i "a b c" = words 3i, 3i+1, 3i+2.
REQ-016 Lane i result SHALL be written to word 3i+2; words 3i and 3i+1 SHALL be zero.
REQ-017 Storage: one assembly register with FMA_COUNT-bit fill mask, and one output register; total depth two lines.
REQ-018 A strobe on lane i with mask bit i clear SHALL write the word and set mask bit i.
REQ-019 A strobe on lane i with mask bit i set SHALL drop the result and set overflow_error_out.
REQ-020 When the mask becomes all-ones (including by strobes in the current cycle), the line SHALL be complete.
REQ-021 A complete line SHALL move to the output register on the next edge if the output register is empty or is being acked that cycle; the mask and assembly register SHALL then clear.
REQ-022 Otherwise the complete line SHALL stay in assembly; ready_out SHALL be 0 while assembly is complete and not transferring.
REQ-023 buffer_valid_out SHALL rise one cycle after transfer and hold, with buffer_read_out stable, until the cycle buffer_ack_in is sampled high.
REQ-024 Ack with buffer_valid_out low SHALL be ignored.
REQ-025 Simultaneous ack and transfer: buffer_valid_out SHALL stay 1 and buffer_read_out SHALL update to the new line.
REQ-026 flush_in with non-zero mask SHALL treat the line as complete (missing words zero); flush_in with zero mask SHALL do nothing.
REQ-027 Strobes arriving while ready_out is 0 SHALL be dropped and set overflow_error_out.
REQ-028 State machine: EMPTY (no output line), HOLD (output valid), STALL (output valid and assembly complete); EMPTY->HOLD on transfer, HOLD->EMPTY on ack without transfer, HOLD->STALL on completion without ack, STALL->HOLD on ack.
REQ-029 Latency: last lane strobe at cycle N -> buffer_valid_out high at N+1 when EMPTY.

Reset
REQ-030 Asserting rst_in SHALL immediately set buffer_read_out=0, buffer_valid_out=0, ready_out=1, overflow_error_out=0, mask=0, state EMPTY.
REQ-031 Reset mid-operation SHALL discard both held lines; no ack is required afterward.
REQ-032 overflow_error_out SHALL clear only on reset.

Structure
REQ-033 WORD_WIDTH, FMA_COUNT, LINE_WIDTH defaults and the state enum SHALL live in shared package gpu_pkg, also used by memory.
REQ-034 Lane-to-line packing SHALL be sub-module fma_line_assembler (assembly register, mask, overflow detect); FSM and output register stay in the top.

Verification
REQ-035 Lanes 0,1 strobe 16'h3C00,16'h4000 same cycle -> next cycle buffer_valid_out=1, buffer_read_out=96'h0000_0000_3C00_0000_0000_4000.
REQ-036 Lane 0 at cycle 0, lane 1 at cycle 3 -> valid rises cycle 4 only; lane 0 strobed twice before lane 1 -> overflow_error_out=1, first value kept.
REQ-037 Hold one line unacked, complete second -> ready_out=0, output unchanged; ack -> second line appears next cycle, valid stays 1.
REQ-038 Lane 1 only = 16'h1234 then flush_in -> output 96'h0000_0000_0000_0000_0000_1234; flush_in with empty mask -> no valid.
REQ-039 rst_in asserted mid-HOLD between clock edges -> buffer_valid_out=0 and ready_out=1 before next edge.
REQ-040 Ack pulse while EMPTY -> no state change, no error.
